// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register for the five-stage MIPS pipeline.
// Captures the ALU result, store data, destination index and control bundle
// on every advancing edge, with stall (hold) and flush (bubble) support, and
// resolves branch_taken for the memory stage.
// Optional feature macro: EX_MEM_OVF_TRAP_EN. When defined, a two-state trap
// FSM squashes a signed-overflowing instruction, records its PC in epc and
// holds exc_req until exc_ack. When undefined, overflow, ovf_chk, exc_ack and
// pc_in are ignored, exc_req/epc are tied to 0 and overflowing instructions
// commit normally (wrap-around semantics).
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic              overflow,
  input  logic              ovf_chk,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic              reg_write,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              exc_ack,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest_reg,
  output logic              branch_taken,
  output logic              exc_req,
  output logic [DATA_W-1:0] epc
);

  // Slot registers
  logic              valid_q,        valid_d;
  logic              reg_write_q,    reg_write_d;
  logic              mem_read_q,     mem_read_d;
  logic              mem_write_q,    mem_write_d;
  logic              mem_to_reg_q,   mem_to_reg_d;
  logic              branch_taken_q, branch_taken_d;
  logic [DATA_W-1:0] alu_result_q,   alu_result_d;
  logic [DATA_W-1:0] store_data_q,   store_data_d;
  logic [REG_W-1:0]  dest_reg_q,     dest_reg_d;

`ifdef EX_MEM_OVF_TRAP_EN
  typedef enum logic {
    IDLE = 1'b0,
    TRAP = 1'b1
  } state_t;

  state_t            state_q,   state_d;
  logic              exc_req_q, exc_req_d;
  logic [DATA_W-1:0] epc_q,     epc_d;
  logic              trap_cond;

  // A checked instruction that overflowed must not commit.
  assign trap_cond = in_valid & ovf_chk & overflow;
`else
  // Trap inputs have no function in this build.
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{overflow, ovf_chk, exc_ack, pc_in};
`endif

  // Next-slot and trap FSM logic; priority is flush > stall > capture.
  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    mem_read_d     = mem_read_q;
    mem_write_d    = mem_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    branch_taken_d = branch_taken_q;
    alu_result_d   = alu_result_q;
    store_data_d   = store_data_q;
    dest_reg_d     = dest_reg_q;
`ifdef EX_MEM_OVF_TRAP_EN
    state_d        = state_q;
    exc_req_d      = exc_req_q;
    epc_d          = epc_q;
`endif

    if (flush) begin
      // Bubble: controls cleared, data held, trap state untouched.
      valid_d        = 1'b0;
      reg_write_d    = 1'b0;
      mem_read_d     = 1'b0;
      mem_write_d    = 1'b0;
      mem_to_reg_d   = 1'b0;
      branch_taken_d = 1'b0;
    end else if (!stall) begin
      alu_result_d   = alu_result;
      store_data_d   = store_data;
      dest_reg_d     = dest_reg;
      valid_d        = in_valid;
      reg_write_d    = reg_write  & in_valid;
      mem_read_d     = mem_read   & in_valid;
      mem_write_d    = mem_write  & in_valid;
      mem_to_reg_d   = mem_to_reg & in_valid;
      branch_taken_d = branch & zero_flag & in_valid;
`ifdef EX_MEM_OVF_TRAP_EN
      if (state_q == TRAP) begin
        // Everything behind the trapping instruction is squashed, including
        // the slot captured on the acknowledging edge.
        valid_d        = 1'b0;
        reg_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        mem_to_reg_d   = 1'b0;
        branch_taken_d = 1'b0;
        if (exc_ack) begin
          state_d   = IDLE;
          exc_req_d = 1'b0;
        end
      end else if (trap_cond) begin
        // The trapping instruction travels on as a valid but inert slot.
        reg_write_d    = 1'b0;
        mem_read_d     = 1'b0;
        mem_write_d    = 1'b0;
        mem_to_reg_d   = 1'b0;
        branch_taken_d = 1'b0;
        epc_d          = pc_in;
        exc_req_d      = 1'b1;
        state_d        = TRAP;
      end
`endif
    end
  end

  // Slot register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      branch_taken_q <= 1'b0;
      alu_result_q   <= '0;
      store_data_q   <= '0;
      dest_reg_q     <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      mem_read_q     <= mem_read_d;
      mem_write_q    <= mem_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      branch_taken_q <= branch_taken_d;
      alu_result_q   <= alu_result_d;
      store_data_q   <= store_data_d;
      dest_reg_q     <= dest_reg_d;
    end
  end

`ifdef EX_MEM_OVF_TRAP_EN
  // Trap FSM state, exception request and exception PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      exc_req_q <= 1'b0;
      epc_q     <= '0;
    end else begin
      state_q   <= state_d;
      exc_req_q <= exc_req_d;
      epc_q     <= epc_d;
    end
  end

  assign exc_req = exc_req_q;
  assign epc     = epc_q;
`else
  assign exc_req = 1'b0;
  assign epc     = '0;
`endif

  assign out_valid      = valid_q;
  assign out_reg_write  = reg_write_q;
  assign out_mem_read   = mem_read_q;
  assign out_mem_write  = mem_write_q;
  assign out_mem_to_reg = mem_to_reg_q;
  assign branch_taken   = branch_taken_q;
  assign out_alu_result = alu_result_q;
  assign out_store_data = store_data_q;
  assign out_dest_reg   = dest_reg_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: directed and randomized checks of ex_mem_reg against a
// behavioural model of the pipeline slot and the overflow trap.
// Follows EX_MEM_OVF_TRAP_EN the same way the design does.
module tb_ex_mem_reg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, in_valid, zero_flag, overflow, ovf_chk;
  logic [DATA_W-1:0] alu_result, store_data, pc_in;
  logic [REG_W-1:0]  dest_reg;
  logic              reg_write, mem_read, mem_write, mem_to_reg, branch, exc_ack;
  logic              out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic [DATA_W-1:0] out_alu_result, out_store_data, epc;
  logic [REG_W-1:0]  out_dest_reg;
  logic              branch_taken, exc_req;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic              m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt, m_exc, m_in_trap;
  logic [DATA_W-1:0] m_alu, m_sd, m_epc;
  logic [REG_W-1:0]  m_dst;

  ex_mem_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .zero_flag(zero_flag), .overflow(overflow),
    .ovf_chk(ovf_chk), .store_data(store_data), .dest_reg(dest_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .pc_in(pc_in), .exc_ack(exc_ack),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
    .out_alu_result(out_alu_result), .out_store_data(out_store_data),
    .out_dest_reg(out_dest_reg), .branch_taken(branch_taken), .exc_req(exc_req),
    .epc(epc)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    {m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt, m_exc, m_in_trap} = '0;
    m_alu = '0; m_sd = '0; m_epc = '0; m_dst = '0;
  endtask

  // One clock edge of the reference: what the memory stage should see next.
  task automatic model_edge();
    bit trap_now, commit, feature;
`ifdef EX_MEM_OVF_TRAP_EN
    feature = 1'b1;
`else
    feature = 1'b0;
`endif
    if (flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_bt} = '0;
    end else if (!stall) begin
      trap_now = feature && !m_in_trap && in_valid && ovf_chk && overflow;
      commit   = in_valid && !m_in_trap && !trap_now;
      m_alu    = alu_result;
      m_sd     = store_data;
      m_dst    = dest_reg;
      m_valid  = in_valid && !m_in_trap;
      m_rw     = reg_write  && commit;
      m_mr     = mem_read   && commit;
      m_mw     = mem_write  && commit;
      m_m2r    = mem_to_reg && commit;
      m_bt     = branch && zero_flag && commit;
      if (m_in_trap && exc_ack) begin
        m_in_trap = 1'b0;
        m_exc     = 1'b0;
      end else if (trap_now) begin
        m_in_trap = 1'b1;
        m_exc     = 1'b1;
        m_epc     = pc_in;
      end
    end
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk(tag, "out_valid",      32'(out_valid),      32'(m_valid));
    chk(tag, "out_reg_write",  32'(out_reg_write),  32'(m_rw));
    chk(tag, "out_mem_read",   32'(out_mem_read),   32'(m_mr));
    chk(tag, "out_mem_write",  32'(out_mem_write),  32'(m_mw));
    chk(tag, "out_mem_to_reg", 32'(out_mem_to_reg), 32'(m_m2r));
    chk(tag, "branch_taken",   32'(branch_taken),   32'(m_bt));
    chk(tag, "exc_req",        32'(exc_req),        32'(m_exc));
    chk(tag, "epc",            epc,                 m_epc);
    // Data outputs are don't-care after a flush but the model tracks the
    // held value, so they are compared unconditionally.
    chk(tag, "out_alu_result", out_alu_result,      m_alu);
    chk(tag, "out_store_data", out_store_data,      m_sd);
    chk(tag, "out_dest_reg",   32'(out_dest_reg),   32'(m_dst));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic clear_inputs();
    {stall, flush, in_valid, zero_flag, overflow, ovf_chk} = '0;
    {reg_write, mem_read, mem_write, mem_to_reg, branch, exc_ack} = '0;
    alu_result = '0; store_data = '0; pc_in = '0; dest_reg = '0;
  endtask

  task automatic rand_instr();
    in_valid   = ($urandom_range(0, 7) != 0);
    alu_result = $urandom;
    store_data = $urandom;
    pc_in      = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    dest_reg   = REG_W'($urandom);
    zero_flag  = 1'($urandom);
    overflow   = 1'($urandom);
    ovf_chk    = ($urandom_range(0, 2) == 0);
    reg_write  = 1'($urandom);
    mem_read   = 1'($urandom);
    mem_write  = 1'($urandom);
    mem_to_reg = 1'($urandom);
    branch     = 1'($urandom);
  endtask

  // Assert reset between edges and confirm it acts without a clock.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #1 check_all("reset_async");
    @(posedge clk); #1 check_all("reset_held");
    @(negedge clk); rst_n = 1'b1;

    // Basic capture
    in_valid = 1; alu_result = 32'h0000_1234; dest_reg = 5'd8; reg_write = 1;
    step("basic_capture");

    // Stall for three cycles with changing inputs, then flush
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      step("stall_hold");
    end
    stall = 0; flush = 1; in_valid = 1; mem_write = 1; reg_write = 1;
    step("flush_bubble");
    flush = 0;

    // Branch resolution
    clear_inputs();
    in_valid = 1; branch = 1; zero_flag = 1; alu_result = 32'h55;
    step("branch_taken_valid");
    in_valid = 0;
    step("branch_taken_invalid");

    // Overflow trap sequence
    clear_inputs();
    in_valid = 1; pc_in = 32'h0040_0010; ovf_chk = 1; overflow = 1; reg_write = 1;
    alu_result = 32'h8000_0000; dest_reg = 5'd9;
    step("trap_enter");
    for (int i = 0; i < 2; i++) begin
      rand_instr(); in_valid = 1; pc_in = 32'h0040_0014 + 32'(4 * i);
      step("trap_squash");
    end
    clear_inputs();
    in_valid = 1; reg_write = 1; ovf_chk = 1; overflow = 1; exc_ack = 1;
    alu_result = 32'h77; dest_reg = 5'd3; pc_in = 32'h0040_001c;
    step("trap_ack");
    exc_ack = 0; ovf_chk = 0; overflow = 0; alu_result = 32'h88; dest_reg = 5'd4;
    step("post_ack_commit");

    // Unchecked overflow commits normally
    in_valid = 1; ovf_chk = 0; overflow = 1; reg_write = 1; alu_result = 32'h7fff_ffff;
    step("ovf_unchecked");

    // Reset in the middle of a trap
    ovf_chk = 1; pc_in = 32'h0040_0100;
    step("trap_enter2");
    async_reset("reset_mid_trap");
    clear_inputs();
    in_valid = 1; reg_write = 1; alu_result = 32'h99;
    step("after_reset_commit");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_instr();
      stall   = ($urandom_range(0, 7) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      exc_ack = ($urandom_range(0, 3) == 0);
      step("random");
      if ($urandom_range(0, 99) == 0) async_reset("random_reset");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound in case the clock or sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
